fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 163 ++++++++++++++++
 tb/tb_fetch_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: requests words from instruction memory, presents them
// to decode with pc, and handles jump/branch redirects, including while a request is in flight.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned ACK_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        branch_ctrl,
    input  logic [31:0] branch_address,
    input  logic        jump_ctrl,
    input  logic [31:0] jump_address,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic        instr_valid,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_VALID = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    // Memory handshake: imem_req/imem_addr are held steady from the cycle a request
    // starts until the single cycle imem_ack is high; imem_rdata is taken only in that
    // cycle. A request, once issued, is never withdrawn early: a redirect waits in DRAIN
    // for the outstanding ack and discards its data.
    // Decode handshake: instr/pc are valid while instr_valid is high; the word is
    // consumed on any edge where instr_valid=1 and stall=0.

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        instr_valid_q, instr_valid_d;
    logic        imem_req_q, imem_req_d;
    logic [31:0] imem_addr_q, imem_addr_d;

    logic        redirect;
    logic [31:0] target;
    logic [31:0] seq_pc;

    // Reserved parameter: no timeout logic is built for any value.
    if (ACK_TIMEOUT != 0) begin : g_ack_timeout_reserved
    end

    always_comb begin
        redirect = jump_ctrl | branch_ctrl;
        target   = jump_ctrl ? jump_address : branch_address;
        seq_pc   = fetch_pc_q + 32'd4;
    end

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        imem_req_d    = imem_req_q;
        imem_addr_d   = imem_addr_q;

        case (state_q)
            S_IDLE: begin
                state_d    = S_FETCH;
                imem_req_d = 1'b1;
                if (redirect) begin
                    fetch_pc_d  = target;
                    imem_addr_d = target;
                end else begin
                    imem_addr_d = fetch_pc_q;
                end
            end

            S_FETCH: begin
                if (imem_ack) begin
                    if (redirect) begin
                        // Returning word belongs to the old stream: drop it and restart.
                        fetch_pc_d  = target;
                        imem_req_d  = 1'b1;
                        imem_addr_d = target;
                    end else begin
                        instr_d       = imem_rdata;
                        pc_d          = fetch_pc_q;
                        fetch_pc_d    = seq_pc;
                        instr_valid_d = 1'b1;
                        imem_req_d    = 1'b0;
                        state_d       = S_VALID;
                    end
                end else if (redirect) begin
                    fetch_pc_d = target;
                    state_d    = S_DRAIN;
                end
            end

            S_DRAIN: begin
                if (redirect) begin
                    fetch_pc_d = target;
                end
                if (imem_ack) begin
                    state_d     = S_FETCH;
                    imem_req_d  = 1'b1;
                    imem_addr_d = redirect ? target : fetch_pc_q;
                end
            end

            S_VALID: begin
                if (redirect) begin
                    instr_valid_d = 1'b0;
                    fetch_pc_d    = target;
                    state_d       = S_FETCH;
                    imem_req_d    = 1'b1;
                    imem_addr_d   = target;
                end else if (!stall) begin
                    instr_valid_d = 1'b0;
                    state_d       = S_FETCH;
                    imem_req_d    = 1'b1;
                    imem_addr_d   = fetch_pc_q;
                end
            end

            default: begin
                state_d       = S_IDLE;
                instr_valid_d = 1'b0;
                imem_req_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            fetch_pc_q    <= RESET_PC;
            pc_q          <= RESET_PC;
            instr_q       <= 32'h0;
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b0;
            imem_addr_q   <= RESET_PC;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            imem_req_q    <= imem_req_d;
            imem_addr_q   <= imem_addr_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = imem_addr_q;
    assign instr       = instr_q;
    assign pc          = pc_q;
    assign instr_valid = instr_valid_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a scoreboard of expected request addresses and
// presented {pc, instr} pairs, checked by a monitor decoupled from the stimulus.
module tb_fetch_sequencer;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_VALID = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;
    localparam int TIMEOUT = 60;

    logic        clk;
    logic        rst;
    logic        branch_ctrl;
    logic [31:0] branch_address;
    logic        jump_ctrl;
    logic [31:0] jump_address;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        instr_valid;
    logic [1:0]  state_dbg;

    logic [63:0] exp_q[$];
    logic [31:0] exp_addr_q[$];
    logic [63:0] mon_e;
    logic        req_prev;
    logic        valid_prev;
    logic        hold_ack;
    logic        spur;
    int          age;
    int          checks;
    int          errors;

    fetch_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .branch_ctrl    (branch_ctrl),
        .branch_address (branch_address),
        .jump_ctrl      (jump_ctrl),
        .jump_address   (jump_address),
        .stall          (stall),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .instr          (instr),
        .pc             (pc),
        .instr_valid    (instr_valid),
        .state_dbg      (state_dbg)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Driver: called at a falling edge; drives inputs plus the memory response, then
    // advances to the next falling edge. Memory acks in the cycle after a request appears.
    task automatic cycle(input logic br, input logic [31:0] ba, input logic jp,
                         input logic [31:0] ja, input logic st);
        branch_ctrl    = br;
        branch_address = ba;
        jump_ctrl      = jp;
        jump_address   = ja;
        stall          = st;
        if (!rst || !imem_req) begin
            age        = 0;
            imem_ack   = spur && rst;
            imem_rdata = spur ? 32'hDEAD_BEEF : 32'h0;
        end else begin
            age = imem_ack ? 1 : age + 1;
            if (!hold_ack && age >= 2) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = 32'h0;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_cycle();
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic wait_valid(input logic [31:0] want);
        int n;
        n = 0;
        while (!(instr_valid === 1'b1 && pc === want) && n < TIMEOUT) begin
            idle_cycle();
            n++;
        end
        if (n >= TIMEOUT) begin
            checks++;
            errors++;
            $display("FAIL wait_valid: no instruction at pc %h within %0d cycles", want, TIMEOUT);
        end
    endtask

    task automatic wait_req(input logic [31:0] want);
        int n;
        n = 0;
        while (!(imem_req === 1'b1 && imem_addr === want) && n < TIMEOUT) begin
            idle_cycle();
            n++;
        end
        if (n >= TIMEOUT) begin
            checks++;
            errors++;
            $display("FAIL wait_req: no request at %h within %0d cycles", want, TIMEOUT);
        end
    endtask

    task automatic push_instr(input logic [31:0] a);
        exp_q.push_back({a, mem_word(a)});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_imem_req"}, 32'(imem_req), 32'h0);
        check({tag, "_imem_addr"}, imem_addr, 32'h0);
        check({tag, "_pc"}, pc, 32'h0);
        check({tag, "_instr"}, instr, 32'h0);
        check({tag, "_instr_valid"}, 32'(instr_valid), 32'h0);
        check({tag, "_state"}, 32'(state_dbg), 32'(ST_IDLE));
    endtask

    initial begin
        rst            = 1'b0;
        branch_ctrl    = 1'b0;
        branch_address = 32'h0;
        jump_ctrl      = 1'b0;
        jump_address   = 32'h0;
        stall          = 1'b0;
        imem_ack       = 1'b0;
        imem_rdata     = 32'h0;
        hold_ack       = 1'b0;
        spur           = 1'b0;
        age            = 0;
        checks         = 0;
        errors         = 0;
        req_prev       = 1'b0;
        valid_prev     = 1'b0;

        // Scoreboard monitor: samples just after each rising edge.
        fork
            forever begin
                @(posedge clk);
                #1;
                if (!rst) begin
                    req_prev   = 1'b0;
                    valid_prev = 1'b0;
                end else begin
                    if (imem_req && (!req_prev || imem_ack)) begin
                        if (exp_addr_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_req: got addr %h, expected none", imem_addr);
                        end else begin
                            check("req_addr", imem_addr, exp_addr_q.pop_front());
                        end
                    end
                    if (instr_valid && !valid_prev) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_instr: got pc %h instr %h, expected none", pc, instr);
                        end else begin
                            mon_e = exp_q.pop_front();
                            check("instr_pc", pc, mon_e[63:32]);
                            check("instr_word", instr, mon_e[31:0]);
                        end
                    end
                    req_prev   = imem_req;
                    valid_prev = instr_valid;
                end
            end
        join_none

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");

        // Sequential fetch from reset
        exp_addr_q.push_back(32'h0);
        exp_addr_q.push_back(32'h4);
        exp_addr_q.push_back(32'h8);
        push_instr(32'h0);
        push_instr(32'h4);
        push_instr(32'h8);
        rst = 1'b1;
        idle_cycle();
        check("first_req", 32'(imem_req), 32'h1);
        check("first_addr", imem_addr, 32'h0);
        wait_valid(32'h8);

        // Stall hold with stray acks while presenting
        exp_addr_q.push_back(32'hC);
        push_instr(32'hC);
        spur = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
            check("stall_instr", instr, mem_word(32'h8));
            check("stall_pc", pc, 32'h8);
            check("stall_valid", 32'(instr_valid), 32'h1);
            check("stall_req", 32'(imem_req), 32'h0);
        end
        spur = 1'b0;
        wait_valid(32'hC);

        // Jump while a request is outstanding
        exp_addr_q.push_back(32'h10);
        exp_addr_q.push_back(32'h100);
        push_instr(32'h100);
        hold_ack = 1'b1;
        wait_req(32'h10);
        cycle(1'b0, 32'h0, 1'b1, 32'h100, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("drain_state", 32'(state_dbg), 32'(ST_DRAIN));
            check("drain_req", 32'(imem_req), 32'h1);
            check("drain_addr", imem_addr, 32'h10);
            idle_cycle();
        end
        hold_ack = 1'b0;
        wait_valid(32'h100);

        // Jump wins over a simultaneous branch
        exp_addr_q.push_back(32'h80);
        push_instr(32'h80);
        cycle(1'b1, 32'h40, 1'b1, 32'h80, 1'b0);
        wait_valid(32'h80);

        // Wrap past the top of memory, then redirect on the ack cycle
        exp_addr_q.push_back(32'hFFFF_FFFC);
        push_instr(32'hFFFF_FFFC);
        exp_addr_q.push_back(32'h0);
        exp_addr_q.push_back(32'h200);
        push_instr(32'h200);
        cycle(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0);
        wait_valid(32'hFFFF_FFFC);
        hold_ack = 1'b1;
        wait_req(32'h0);
        idle_cycle();
        hold_ack = 1'b0;
        cycle(1'b0, 32'h0, 1'b1, 32'h200, 1'b0);
        check("ackredir_state", 32'(state_dbg), 32'(ST_FETCH));
        check("ackredir_addr", imem_addr, 32'h200);
        check("ackredir_valid", 32'(instr_valid), 32'h0);
        wait_valid(32'h200);

        // Reset while draining an old request
        exp_addr_q.push_back(32'h20);
        cycle(1'b1, 32'h20, 1'b0, 32'h0, 1'b0);
        hold_ack = 1'b1;
        wait_req(32'h20);
        cycle(1'b0, 32'h0, 1'b1, 32'h300, 1'b0);
        check("pre_reset_state", 32'(state_dbg), 32'(ST_DRAIN));
        check("pre_reset_addr", imem_addr, 32'h20);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 32'h500, 1'b1, 32'h600, 1'b0);
        end
        hold_ack = 1'b0;
        exp_addr_q.push_back(32'h0);
        push_instr(32'h0);
        rst = 1'b1;
        idle_cycle();
        check("rerelease_req", 32'(imem_req), 32'h1);
        check("rerelease_addr", imem_addr, 32'h0);
        wait_valid(32'h0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        end

        check("exp_addr_left", 32'(exp_addr_q.size()), 32'h0);
        check("exp_instr_left", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
